// File: rtl/tnoc_flit_if_demux.sv
// NoC flit types, the flit interface, and a 1-to-ENTRIES flit interface demux.
// The demux steers each packet by the select seen with its head flit and keeps that route per VC.
package tnoc_pkg;
  typedef struct packed {
    int virtual_channels;
  } tnoc_config_t;

  localparam tnoc_config_t TNOC_DEFAULT_CONFIG = '{virtual_channels: 2};

  typedef enum logic {
    TNOC_BODY_FLIT = 1'b0,
    TNOC_HEAD_FLIT = 1'b1
  } tnoc_flit_type_t;

  typedef struct packed {
    tnoc_flit_type_t flit_type;
    logic            tail;
    logic [31:0]     data;
  } tnoc_flit_t;
endpackage

interface tnoc_flit_if #(
  parameter tnoc_pkg::tnoc_config_t CONFIG = tnoc_pkg::TNOC_DEFAULT_CONFIG
) ();
  localparam int CHANNELS = CONFIG.virtual_channels;

  logic [CHANNELS-1:0]  valid;
  logic [CHANNELS-1:0]  ready;
  logic [CHANNELS-1:0]  vc_available;
  tnoc_pkg::tnoc_flit_t flit;

  modport initiator (output valid, input ready, input vc_available, output flit);
  modport target    (input valid, output ready, output vc_available, input flit);
endinterface

module tnoc_flit_if_demux
  import tnoc_pkg::*;
#(
  parameter tnoc_config_t CONFIG   = TNOC_DEFAULT_CONFIG,
  parameter int           CHANNELS = CONFIG.virtual_channels,
  parameter int           ENTRIES  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ENTRIES-1:0] i_select,
  tnoc_flit_if.target        flit_in_if,
  tnoc_flit_if.initiator     flit_out_if [ENTRIES],
  output logic               o_error
);
  typedef enum logic {
    IDLE,
    ROUTED
  } state_t;

  state_t              state_q   [CHANNELS];
  state_t              state_d   [CHANNELS];
  logic [ENTRIES-1:0]  route_q   [CHANNELS];
  logic [ENTRIES-1:0]  route_d   [CHANNELS];
  logic [ENTRIES-1:0]  eff       [CHANNELS];
  logic [ENTRIES-1:0]  fwd       [CHANNELS];
  logic [CHANNELS-1:0] out_ready [ENTRIES];
  logic [CHANNELS-1:0] out_avail [ENTRIES];
  logic [CHANNELS-1:0] out_valid [ENTRIES];
  logic [CHANNELS-1:0] in_ready;
  logic [CHANNELS-1:0] in_avail;
  logic [CHANNELS-1:0] accepted;
  logic [ENTRIES-1:0]  sel_lowest;
  tnoc_flit_t          flit;
  logic                is_head;
  logic                is_tail;
  logic                error_d;

  assign flit    = flit_in_if.flit;
  assign is_head = (flit.flit_type == TNOC_HEAD_FLIT);
  assign is_tail = flit.tail;

  // Isolate the lowest set bit so a multi-hot select behaves as its lowest index.
  assign sel_lowest = i_select & ~(i_select - ENTRIES'(1));

  for (genvar i = 0; i < ENTRIES; i++) begin : g_out
    assign flit_out_if[i].flit  = flit_in_if.flit;
    assign flit_out_if[i].valid = out_valid[i];
    assign out_ready[i]         = flit_out_if[i].ready;
    assign out_avail[i]         = flit_out_if[i].vc_available;
  end

  assign flit_in_if.ready        = in_ready;
  assign flit_in_if.vc_available = in_avail;
  assign accepted                = flit_in_if.valid & in_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    for (int i = 0; i < ENTRIES; i++) begin
      out_valid[i] = '0;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      eff[c] = (state_q[c] == ROUTED) ? route_q[c] : sel_lowest;
      // A non-head flit on an unrouted VC is forwarded nowhere and swallowed.
      fwd[c]      = ((state_q[c] == ROUTED) || is_head) ? eff[c] : '0;
      in_ready[c] = (state_q[c] == IDLE) && !is_head;
      in_avail[c] = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        in_ready[c]     = in_ready[c] | (fwd[c][i] & out_ready[i][c]);
        in_avail[c]     = in_avail[c] | (eff[c][i] & out_avail[i][c]);
        out_valid[i][c] = flit_in_if.valid[c] & fwd[c][i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    error_d = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (accepted[c]) begin
        if (state_q[c] == IDLE) begin
          if (!is_head) begin
            error_d = 1'b1;
          end else if (!is_tail) begin
            state_d[c] = ROUTED;
            route_d[c] = eff[c];
          end
        end else if (is_tail) begin
          state_d[c] = IDLE;
          route_d[c] = '0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: route_q is a handful of flops, not a RAM, so it is reset along with the state.
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= IDLE;
        route_q[c] <= '0;
      end
      o_error <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      o_error <= error_d;
    end
  end
endmodule

// File: doc/tnoc_flit_if_demux.md
Name: tnoc_flit_if_demux

Overview:
- One flit interface in, ENTRIES flit interfaces out. Each packet is steered to the output chosen by i_select when its head flit is accepted.
- The route is held per virtual channel until the tail flit is accepted, so packet bodies follow their head flit without needing routing information.
- Sits at router/port fan-out points. It is the complement of the N-to-1 flit interface mux.

Parameters:
CONFIG, TNOC_DEFAULT_CONFIG, NoC configuration (flit layout, virtual_channels)
CHANNELS, CONFIG.virtual_channels, number of virtual channels
ENTRIES, 2, number of output flit interfaces (>=2)

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, synchronous, active-high
i_select  input  ENTRIES  one-hot output select; sampled only on an accepted head flit
flit_in_if  tnoc_flit_if.target  -  upstream flit interface (valid/ready/vc_available per VC, shared flit bus)
flit_out_if[ENTRIES]  tnoc_flit_if.initiator  -  downstream flit interfaces
o_error  output  1  one-cycle pulse: non-head flit accepted on an unrouted VC

Behaviour:
- One clock, i_clk; reset is synchronous and active-high on i_rst.
- Head and tail flags are decoded from flit_in_if.flit using the codebase flit field definitions.
- Upstream guarantees at most one flit_in_if.valid bit per cycle. The flit bus belongs to that VC.

Per-VC state machine (CHANNELS independent copies):
- States: IDLE, ROUTED. Each copy holds a latched select register route_q[c] of ENTRIES bits.
- Reset: every VC goes to IDLE and route_q = 0. o_error = 0.
- Effective route eff[c]:
  - IDLE: i_select after multi-hot reduction (lowest set index wins).
  - ROUTED: route_q[c].
- IDLE + accepted head flit with tail=0: go to ROUTED and load route_q[c] with eff[c].
- IDLE + accepted head flit with tail=1 (single-flit packet): forward the flit and stay in IDLE.
- ROUTED + accepted tail flit: go to IDLE and clear route_q[c].
- ROUTED + head flit: it is forwarded on route_q[c] and the state is unchanged. No re-route occurs mid-packet.
- "Accepted" means flit_in_if.valid[c] & flit_in_if.ready[c].

Datapath (combinational, zero latency):
- flit_out_if[i].flit = flit_in_if.flit for all i (broadcast).
- flit_out_if[i].valid[c] = flit_in_if.valid[c] & eff[c][i].
- flit_in_if.ready[c] = OR over i of (eff[c][i] & flit_out_if[i].ready[c]).
- flit_in_if.vc_available[c] = OR over i of (eff[c][i] & flit_out_if[i].vc_available[c]).
  - The input therefore shows availability of the routed/selected output only.
  - It shows 0 when eff[c] = 0.

Boundary conditions:
- IDLE with i_select = 0 and a head flit present: no output valid, ready = 0. The flit is held until the select becomes non-zero.
- IDLE with a non-head flit (protocol error):
  - ready[c] = 1 and no output valid, so the flit is dropped.
  - o_error pulses high in the next cycle (registered). The state stays IDLE.
- Multi-hot i_select: only the lowest index is used, both for forwarding and for latching.
- Interleaved VCs:
  - A packet on VC0 routed to output 1 and a packet on VC1 routed to output 0 progress independently.
  - Each uses its own route_q.
- Reset mid-packet: all VCs return to IDLE. Remaining body flits of that packet hit the protocol-error path.
- Backpressure: valid may stay high across stalled cycles. Route and state change only on acceptance.

Test Plan:
1. Reset, then a 4-flit packet on VC0 with i_select=01 at the head and i_select=10 afterwards -> all 4 flits appear on out[0] only. VC0 returns to IDLE after the tail. out[1].valid stays 0.
2. Single-flit packet (head=tail=1) on VC1 with i_select=10 -> forwarded on out[1] in the same cycle. VC1 stays IDLE and route_q[1] stays 0.
3. VC0 packet to out[0] and VC1 packet to out[1], interleaved flit by flit, with out[0].ready[0] held low 3 cycles -> the VC0 flit is held stable for those 3 cycles. VC1 flits pass throughout and no flit is lost or duplicated.
4. Head flit with i_select=00 for 2 cycles, then 10 -> flit_in_if.ready=0 for 2 cycles. The flit is accepted on cycle 3 and appears on out[1].
5. Body flit on an IDLE VC -> ready=1, no output valid, o_error=1 for exactly one cycle afterwards. i_select=11 on a head flit -> routed to out[0].
6. Assert i_rst after 2 of 4 flits of a packet -> all VCs IDLE and o_error=0 during reset. The next body flit raises o_error, and a fresh head flit with i_select=10 routes to out[1].
